// File: rtl/hamming_frame_controller.sv
// -----------------------------------------------------------------------------
// hamming_frame_controller
//
// Buffers Hamming(7,4) codewords arriving from a UART front end, hands them one
// at a time to an external decoder, and presents each decoded nibble to a
// downstream consumer with a valid/ready handshake.
//
// Handshake rule (consumer side): out_valid rises with a result and the result
// fields stay frozen until out_ready is sampled high while out_valid is high;
// out_valid falls on the following cycle unless another result is ready.
// The decoder side is a request/response pair: a one-cycle dec_ena per
// codeword, dec_code held until dec_valid (or the timeout) closes it; only one
// codeword is ever outstanding.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   rx_valid, rx_code          incoming codeword pulse
//   dec_ena, dec_code          decode request to the decoder
//   dec_valid, dec_data,
//   dec_syndrome               decoder response
//   out_valid, out_ready,
//   out_data, out_syndrome,
//   out_corrected, out_timeout result to the consumer
//   fifo_level, overflow, busy status
//
// Build option: define HFC_TIMEOUT_EN to abort a decode that has not answered
// within TIMEOUT_CYCLES cycles of dec_ena; the aborted result carries zero data
// and out_timeout = 1. Without the macro no timeout counter exists.
// -----------------------------------------------------------------------------
module hamming_frame_controller #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [6:0] rx_code,
  output logic       dec_ena,
  output logic [6:0] dec_code,
  input  logic       dec_valid,
  input  logic [3:0] dec_data,
  input  logic [2:0] dec_syndrome,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [2:0] out_syndrome,
  output logic       out_corrected,
  output logic       out_timeout,
  output logic [4:0] fifo_level,
  output logic       overflow,
  output logic       busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Last counter value before the abort fires; the counter reads 1 in the
  // first WAIT cycle, so aborting here puts out_valid TIMEOUT_CYCLES after dec_ena.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t           state_q;
  logic [6:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]       level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             dec_ena_q;
  logic [6:0]       dec_code_q;
  logic             out_valid_q;
  logic [3:0]       out_data_q;
  logic [2:0]       out_syn_q;
  logic             out_corr_q;
  logic             fifo_empty, fifo_full, push, pop;
  logic [6:0]       head;

  assign fifo_empty = (level_q == 5'd0);
  assign fifo_full  = (level_q == 5'(FIFO_DEPTH));
  assign head       = mem_q[rd_ptr_q];

  // The FSM pops the head whenever it launches a new decode request.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      IDLE:    pop = !fifo_empty;
      HOLD:    pop = out_ready && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push = rx_valid && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d    = level_q;
    if (push && !pop) level_d = level_q + 5'd1;
    if (pop && !push) level_d = level_q - 5'd1;
    overflow_d = overflow_q || (rx_valid && !push);
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= rx_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= 5'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef HFC_TIMEOUT_EN
  logic [7:0] to_cnt_q;
  logic       out_to_q;
`else
  logic       unused_timeout_cfg;
  assign unused_timeout_cfg = ^TO_LAST;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dec_ena_q   <= 1'b0;
      dec_code_q  <= 7'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 4'd0;
      out_syn_q   <= 3'd0;
      out_corr_q  <= 1'b0;
`ifdef HFC_TIMEOUT_EN
      to_cnt_q    <= 8'd0;
      out_to_q    <= 1'b0;
`endif
    end else begin
      dec_ena_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q    <= ISSUE;
            dec_ena_q  <= 1'b1;
            dec_code_q <= head;
          end
        end
        ISSUE: begin
          state_q  <= WAIT;
`ifdef HFC_TIMEOUT_EN
          to_cnt_q <= 8'd1;
`endif
        end
        WAIT: begin
          // A real answer beats a timeout landing in the same cycle.
          if (dec_valid) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= dec_data;
            out_syn_q   <= dec_syndrome;
            out_corr_q  <= |dec_syndrome;
`ifdef HFC_TIMEOUT_EN
            out_to_q    <= 1'b0;
`endif
          end
`ifdef HFC_TIMEOUT_EN
          else if (to_cnt_q >= TO_LAST) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= 4'd0;
            out_syn_q   <= 3'd0;
            out_corr_q  <= 1'b0;
            out_to_q    <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
`endif
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (!fifo_empty) begin
              state_q    <= ISSUE;
              dec_ena_q  <= 1'b1;
              dec_code_q <= head;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign dec_ena       = dec_ena_q;
  assign dec_code      = dec_code_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_syndrome  = out_syn_q;
  assign out_corrected = out_corr_q;
`ifdef HFC_TIMEOUT_EN
  assign out_timeout   = out_to_q;
`else
  assign out_timeout   = 1'b0;
`endif
  assign fifo_level    = level_q;
  assign overflow      = overflow_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_hamming_frame_controller.sv
// -----------------------------------------------------------------------------
// Bench for hamming_frame_controller (FIFO_DEPTH = 4, TIMEOUT_CYCLES = 15).
// Stimulus pushes expected results into exp_q; the monitor pops one on every
// out_valid/out_ready handshake. A small decoder model answers dec_ena three
// cycles later from resp_q when dec_auto is set.
// -----------------------------------------------------------------------------
module tb_hamming_frame_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [6:0] rx_code = 7'd0;
  logic       dec_ena;
  logic [6:0] dec_code;
  logic       dec_valid = 1'b0;
  logic [3:0] dec_data = 4'd0;
  logic [2:0] dec_syndrome = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [2:0] out_syndrome;
  logic       out_corrected;
  logic       out_timeout;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       busy;

  hamming_frame_controller #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_code(rx_code),
    .dec_ena(dec_ena), .dec_code(dec_code),
    .dec_valid(dec_valid), .dec_data(dec_data), .dec_syndrome(dec_syndrome),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_syndrome(out_syndrome), .out_corrected(out_corrected),
    .out_timeout(out_timeout),
    .fifo_level(fifo_level), .overflow(overflow), .busy(busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass = 0;
  logic [8:0] exp_q[$];       // {data, syndrome, corrected, timeout}
  logic [6:0] exp_code_q[$];  // codes the decoder model expects to see
  logic [6:0] resp_q[$];      // {data, syndrome} the decoder model returns
  logic [6:0] tx_q[$];        // burst queue for back-to-back sends
  bit         dec_auto = 1'b0;
  int         dec_ena_cnt = 0;
  int         valid_cycles = 0;
  bit         prev_hold = 1'b0;
  logic [8:0] prev_out = '0;
  logic [8:0] out_bus;

  assign out_bus = {out_data, out_syndrome, out_corrected, out_timeout};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_stable", out_bus, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", out_valid, 0);
        else check("out_result", out_bus, exp_q.pop_front());
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = out_bus;
      if (out_valid) valid_cycles++;
      if (dec_ena) dec_ena_cnt++;
    end
  end

  // ---------------- decoder model ----------------
  initial begin
    logic [6:0] c;
    logic [6:0] r;
    forever begin
      @(negedge clk);
      if (!rst && dec_ena && dec_auto) begin
        if (resp_q.size() == 0 || exp_code_q.size() == 0) begin
          check("dec_model_unexpected_ena", dec_ena, 0);
        end else begin
          c = exp_code_q.pop_front();
          r = resp_q.pop_front();
          check("dec_code", dec_code, c);
          repeat (3) @(posedge clk);
          #1;
          check("dec_code_stable", dec_code, c);
          dec_data = r[6:3]; dec_syndrome = r[2:0]; dec_valid = 1'b1;
          @(posedge clk); #1;
          dec_valid = 1'b0; dec_data = 4'd0; dec_syndrome = 3'd0;
          @(negedge clk);
          check("dec_to_out_latency", out_valid, 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic send(input logic [6:0] code);
    @(posedge clk); #1; rx_valid = 1'b1; rx_code = code;
    @(posedge clk); #1; rx_valid = 1'b0;
  endtask

  task automatic send_burst();
    while (tx_q.size() != 0) begin
      @(posedge clk); #1; rx_valid = 1'b1; rx_code = tx_q.pop_front();
    end
    @(posedge clk); #1; rx_valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [6:0] code, input logic [3:0] d,
                              input logic [2:0] s, input logic corr);
    exp_code_q.push_back(code);
    resp_q.push_back({d, s});
    exp_q.push_back({d, s, corr, 1'b0});
  endtask

  task automatic drive_dec(input logic [3:0] d, input logic [2:0] s);
    @(posedge clk); #1; dec_valid = 1'b1; dec_data = d; dec_syndrome = s;
    @(posedge clk); #1; dec_valid = 1'b0; dec_data = 4'd0; dec_syndrome = 3'd0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || resp_q.size() != 0) && k < budget) begin
      @(negedge clk); k++;
    end
    check("drain_in_time", exp_q.size() + resp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    do_reset();
    @(negedge clk);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_busy", busy, 0);
    check("rst_dec_ena", dec_ena, 0);
    check("rst_dec_code", dec_code, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_fields", out_bus, 0);
    check("rst_overflow", overflow, 0);

    // Single frame with latency probe
    out_ready = 1'b1; dec_auto = 1'b1; valid_cycles = 0;
    expect_frame(7'h55, 4'hA, 3'd0, 1'b0);
    @(posedge clk); #1; rx_valid = 1'b1; rx_code = 7'h55;
    @(posedge clk); #1; rx_valid = 1'b0;
    @(negedge clk);
    check("single_level_after_push", fifo_level, 1);
    check("single_no_early_ena", dec_ena, 0);
    @(negedge clk);
    check("single_ena_latency", dec_ena, 1);
    check("single_dec_code", dec_code, 7'h55);
    wait_drain(50);
    check("single_valid_one_cycle", valid_cycles, 1);
    check("single_back_idle", busy, 0);

    // Backpressure: three back to back, consumer stalled
    out_ready = 1'b0; dec_ena_cnt = 0;
    expect_frame(7'h33, 4'h3, 3'd0, 1'b0);
    expect_frame(7'h4B, 4'hB, 3'd0, 1'b0);
    expect_frame(7'h1E, 4'h6, 3'b010, 1'b1);
    tx_q.push_back(7'h33); tx_q.push_back(7'h4B); tx_q.push_back(7'h1E);
    send_burst();
    repeat (20) @(negedge clk);
    check("bp_one_ena", dec_ena_cnt, 1);
    check("bp_fifo_level", fifo_level, 2);
    check("bp_result_held", out_valid, 1);
    @(posedge clk); #1; out_ready = 1'b1;
    wait_drain(100);
    check("bp_total_ena", dec_ena_cnt, 3);

    // Error flag
    expect_frame(7'h2D, 4'h5, 3'b101, 1'b1);
    send(7'h2D);
    wait_drain(50);

    // Full buffer: simultaneous push and pop is accepted
    do_reset();
    out_ready = 1'b0; dec_auto = 1'b1;
    for (int i = 1; i <= 6; i++) expect_frame(7'(i), 4'(i), 3'd0, 1'b0);
    for (int i = 1; i <= 5; i++) tx_q.push_back(7'(i));
    send_burst();
    repeat (12) @(negedge clk);
    check("full_level", fifo_level, 4);
    check("full_holding", out_valid, 1);
    @(posedge clk); #1; out_ready = 1'b1; rx_valid = 1'b1; rx_code = 7'd6;
    @(posedge clk); #1; rx_valid = 1'b0;
    @(negedge clk);
    check("full_push_pop_level", fifo_level, 4);
    check("full_push_pop_no_ovf", overflow, 0);
    wait_drain(200);
    check("full_no_ovf_end", overflow, 0);

    // Overflow: decoder stalled, six pulses
    do_reset();
    dec_auto = 1'b0; out_ready = 1'b1; dec_ena_cnt = 0;
    tx_q.push_back(7'h11); tx_q.push_back(7'h22); tx_q.push_back(7'h33);
    tx_q.push_back(7'h44); tx_q.push_back(7'h55); tx_q.push_back(7'h66);
    send_burst();
    repeat (3) @(negedge clk);
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_inflight_code", dec_code, 7'h11);
    check("ovf_one_ena", dec_ena_cnt, 1);
    check("ovf_busy", busy, 1);
    exp_q.push_back({4'h1, 3'd0, 1'b0, 1'b0});
    expect_frame(7'h22, 4'h2, 3'd0, 1'b0);
    expect_frame(7'h33, 4'h3, 3'd0, 1'b0);
    expect_frame(7'h44, 4'h4, 3'd0, 1'b0);
    expect_frame(7'h55, 4'h5, 3'd0, 1'b0);
    dec_auto = 1'b1;
    drive_dec(4'h1, 3'd0);
    wait_drain(200);
    check("ovf_total_ena", dec_ena_cnt, 5);
    check("ovf_sticky", overflow, 1);
    do_reset();
    @(negedge clk);
    check("ovf_cleared_by_rst", overflow, 0);

    // Timeout behaviour
    dec_auto = 1'b0; out_ready = 1'b1;
`ifdef HFC_TIMEOUT_EN
    exp_q.push_back({4'h0, 3'd0, 1'b0, 1'b1});
    send(7'h77);
    k = 0;
    while (!dec_ena && k < 10) begin @(negedge clk); k++; end
    check("to_ena_seen", dec_ena, 1);
    k = 0;
    while (k < 40) begin
      @(negedge clk); k++;
      if (out_valid) break;
    end
    check("to_latency", k, 15);
    check("to_flag", out_timeout, 1);
    check("to_data_zero", out_data, 0);
    wait_drain(20);
    // Answer landing on the timeout cycle wins
    exp_q.push_back({4'h9, 3'd0, 1'b0, 1'b0});
    send(7'h78);
    k = 0;
    while (!dec_ena && k < 10) begin @(negedge clk); k++; end
    repeat (14) @(posedge clk);
    #1; dec_valid = 1'b1; dec_data = 4'h9;
    @(posedge clk); #1; dec_valid = 1'b0; dec_data = 4'h0;
    @(negedge clk);
    check("to_race_result_wins", out_timeout, 0);
    wait_drain(20);
`else
    send(7'h77);
    repeat (40) @(negedge clk);
    check("nto_still_waiting", busy, 1);
    check("nto_no_valid", out_valid, 0);
    check("nto_flag_zero", out_timeout, 0);
    exp_q.push_back({4'h7, 3'd0, 1'b0, 1'b0});
    drive_dec(4'h7, 3'd0);
    wait_drain(20);
`endif

    // Reset mid-WAIT with codewords buffered
    dec_auto = 1'b0; out_ready = 1'b1;
    tx_q.push_back(7'h0F); tx_q.push_back(7'h1F); tx_q.push_back(7'h2F);
    send_burst();
    repeat (6) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    check("midrst_level_before", fifo_level, 2);
    @(posedge clk); #1; rst = 1'b1; rx_valid = 1'b1; rx_code = 7'h7F;
    @(posedge clk); #1; rst = 1'b0; rx_valid = 1'b0;
    valid_cycles = 0;
    dec_valid = 1'b1; dec_data = 4'hF;
    @(posedge clk); #1; dec_valid = 1'b0; dec_data = 4'h0;
    @(negedge clk);
    check("midrst_level", fifo_level, 0);
    check("midrst_busy", busy, 0);
    drive_dec(4'hE, 3'd1);
    repeat (10) @(negedge clk);
    check("midrst_no_valid", valid_cycles, 0);
    check("midrst_idle", busy, 0);
    check("midrst_level_end", fifo_level, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hamming_frame_controller.md
HAMMING_FRAME_CONTROLLER -- requirements
Module: hamming_frame_controller

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, codeword buffer depth; power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 15, decoder response limit in cycles; 1..255.
REQ-003 Ports: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset.
REQ-004 UART side:
- rx_valid  in  1  one-cycle pulse, codeword present.
- rx_code  in  7  Hamming(7,4) codeword.
REQ-005 Decoder side:
- dec_ena  out  1  one-cycle decode request.
- dec_code  out  7  codeword under decode; held stable from dec_ena until response or abort.
- dec_valid  in  1  decoder result pulse.
- dec_data  in  4  decoded nibble.
- dec_syndrome  in  3  syndrome.
REQ-006 Consumer side:
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_data  out  4  nibble.
- out_syndrome  out  3  syndrome.
- out_corrected  out  1  syndrome nonzero.
- out_timeout  out  1  result aborted by timeout.
REQ-007 Status outputs:
- fifo_level  out  5  entries buffered.
- overflow  out  1  sticky; rx_valid arrived while the buffer was full.
- busy  out  1  state machine not in IDLE.

Function
REQ-008 Buffer: FIFO_DEPTH-entry FIFO; writes on rx_valid; read pointer and write pointer wrap modulo FIFO_DEPTH.
REQ-009 Full FIFO on rx_valid: discard the codeword, set overflow, leave stored contents unchanged.
REQ-010 Simultaneous rx_valid and pop on a full FIFO: accept the write and do not set overflow.
REQ-011 States IDLE, ISSUE, WAIT, HOLD.
REQ-012 IDLE -> ISSUE when FIFO is non-empty.
REQ-013 In ISSUE:
- pop the head into dec_code;
- assert dec_ena for exactly one cycle;
- transition to WAIT.
REQ-014 WAIT -> HOLD on dec_valid:
- latch dec_data and dec_syndrome;
- out_corrected = |dec_syndrome;
- out_timeout = 0.
REQ-015 dec_valid outside WAIT is ignored.
REQ-016 In HOLD, out_valid = 1. Outputs hold stable until out_ready is sampled high.
REQ-017 From HOLD on out_ready:
- go to ISSUE if the FIFO is non-empty, else IDLE;
- out_valid falls the next cycle.
REQ-018 Latency: rx_valid into an empty FIFO in IDLE -> dec_ena 2 cycles later.
REQ-019 Latency: dec_valid -> out_valid 1 cycle later.
REQ-020 Only one codeword is outstanding at the decoder at any time.
REQ-021 fifo_level is updated the cycle after each push or pop. A simultaneous push and pop leaves it unchanged.

Reset
REQ-022 When rst is high at a clock edge:
- state = IDLE;
- FIFO pointers = 0 and fifo_level = 0;
- dec_ena, out_valid, out_corrected, out_timeout, overflow, busy = 0;
- dec_code, out_data, out_syndrome = 0.
REQ-023 Reset mid-operation (WAIT or HOLD):
- the in-flight result and all buffered codewords are discarded;
- a dec_valid in the cycle after reset is ignored.
REQ-024 rst takes priority over rx_valid in the same cycle; the codeword is not stored.

Configuration
REQ-025 Macro HFC_TIMEOUT_EN defined: a counter starts at dec_ena. If dec_valid has not arrived TIMEOUT_CYCLES cycles after dec_ena:
- WAIT -> HOLD;
- out_data = 0, out_syndrome = 0, out_timeout = 1, out_corrected = 0.
REQ-026 Timeout with a simultaneous dec_valid: the result wins and out_timeout = 0.
REQ-027 Macro HFC_TIMEOUT_EN undefined: WAIT exits only on dec_valid; out_timeout is tied to 0; no timeout counter is synthesized.

Verification
REQ-028 Single frame:
- stimulus: rx_code=7'h55 with rx_valid; decoder answers dec_data=4'hA, dec_syndrome=0 three cycles after dec_ena; out_ready held 1;
- response: dec_code=7'h55; out_valid for 1 cycle with out_data=4'hA, out_corrected=0.
REQ-029 Backpressure:
- stimulus: 3 codewords back to back; out_ready=0 for 20 cycles;
- response: only one dec_ena issued; fifo_level=2; first result held stable; remaining two follow in order after out_ready=1.
REQ-030 Overflow:
- stimulus: 6 rx_valid pulses with the decoder stalled, FIFO_DEPTH=4;
- response: first decode in flight; 4 codewords buffered; 1 dropped; overflow=1 until rst.
REQ-031 Error flag:
- stimulus: decoder returns dec_syndrome=3'b101;
- response: out_syndrome=5, out_corrected=1.
REQ-032 Timeout (HFC_TIMEOUT_EN):
- stimulus: decoder never responds;
- response: out_valid exactly 15 cycles after dec_ena; out_timeout=1; out_data=0.
REQ-033 Reset mid-WAIT:
- stimulus: assert rst with 2 codewords buffered, then release;
- response: fifo_level=0, busy=0, no out_valid even if dec_valid pulses afterwards.
